// File: rtl/maze_generator_pkg.sv
// Shared maze definitions: tile values, direction codes, FSM states, LFSR constants
// and the tile-address helper that the player-movement logic also uses.
package maze_generator_pkg;

  localparam logic FLOOR = 1'b0;
  localparam logic WALL  = 1'b1;

  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  localparam logic [15:0] LFSR_ZERO_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_RIGHT = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [3:0] {
    ST_IDLE, ST_FILL, ST_SEED, ST_PICK, ST_PROBE, ST_CARVE, ST_POP, ST_EXIT, ST_DONE
  } state_t;

  // Row-major tile address; legal maze sizes never exceed 2048 tiles.
  function automatic logic [10:0] tile_addr(input logic [10:0] width,
                                            input logic [7:0]  x,
                                            input logic [7:0]  y);
    return width * {3'b000, y} + {3'b000, x};
  endfunction

endpackage

// File: rtl/maze_lfsr16.sv
// 16-bit Galois LFSR with synchronous seed load; an all-zero seed would lock up,
// so it is replaced by a fixed non-zero value.
module maze_lfsr16
  import maze_generator_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        enable,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= LFSR_ZERO_SEED;
    end else if (load) begin
      state <= (seed == 16'h0000) ? LFSR_ZERO_SEED : seed;
    end else if (enable) begin
      state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/maze_generator.sv
// Randomised depth-first backtracker that carves a perfect maze into a 1-bit tile
// RAM, using the RAM itself as the visited map (WALL = not yet visited).
module maze_generator
  import maze_generator_pkg::*;
#(
  parameter int WIDTH        = 10,
  parameter int HEIGHT       = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] rand_seed,
  input  logic        maze_read_data,
  output logic [10:0] maze_address,
  output logic        maze_write_enable,
  output logic        maze_write_data,
  output logic        busy,
  output logic        done
);

  localparam int XL          = ((WIDTH - 1) / 2) * 2;
  localparam int YL          = ((HEIGHT - 1) / 2) * 2;
  localparam int CELLS       = (XL / 2 + 1) * (YL / 2 + 1);
  localparam int SP_W        = $clog2(CELLS + 1);
  localparam int STACK_DEPTH = 2 ** SP_W;

  localparam logic [10:0] W11       = 11'(WIDTH);
  localparam logic [10:0] LAST_ADDR = 11'(WIDTH * HEIGHT - 1);
  localparam logic [7:0]  XL8       = 8'(XL);
  localparam logic [7:0]  YL8       = 8'(YL);
  localparam logic [7:0]  EXIT_Y    = 8'(HEIGHT - 1);
  localparam logic [7:0]  RL8       = 8'(READ_LATENCY);

  state_t          state_reg, state_next;
  logic [10:0]     fill_reg, fill_next;
  logic [SP_W-1:0] sp_reg, sp_next;
  logic [1:0]      dir_base_reg, dir_base_next;
  logic [2:0]      dir_cnt_reg, dir_cnt_next;
  logic [7:0]      nb_x_reg, nb_x_next, nb_y_reg, nb_y_next;
  logic [7:0]      wait_reg, wait_next;
  logic            phase_reg, phase_next;
  logic [10:0]     addr_next;
  logic            we_next, wd_next, busy_next, done_next;

  logic            lfsr_load;
  logic [15:0]     lfsr;
  logic            unused_lfsr_bits;
  logic            push;
  logic [15:0]     push_data;
  logic [15:0]     stack [STACK_DEPTH];

  logic [15:0]     top;
  logic [7:0]      cur_x, cur_y, nx, ny, mid_x, mid_y;
  logic [1:0]      base;
  dir_t            dir;
  logic            in_bounds;

  maze_lfsr16 u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .load   (lfsr_load),
    .enable (busy),
    .seed   (rand_seed),
    .state  (lfsr)
  );

  assign unused_lfsr_bits = ^lfsr[15:2];

  // Neighbour selection; bounds are tested before any subtraction.
  always_comb begin
    top       = stack[sp_reg - SP_W'(1)];
    cur_x     = top[15:8];
    cur_y     = top[7:0];
    base      = (dir_cnt_reg == 3'd0) ? lfsr[1:0] : dir_base_reg;
    dir       = dir_t'(base + dir_cnt_reg[1:0]);
    nx        = cur_x;
    ny        = cur_y;
    in_bounds = 1'b0;
    case (dir)
      DIR_UP: if (cur_y >= 8'd2) begin
        in_bounds = 1'b1;
        ny        = cur_y - 8'd2;
      end
      DIR_DOWN: if (({1'b0, cur_y} + 9'd2) <= {1'b0, YL8}) begin
        in_bounds = 1'b1;
        ny        = cur_y + 8'd2;
      end
      DIR_RIGHT: if (({1'b0, cur_x} + 9'd2) <= {1'b0, XL8}) begin
        in_bounds = 1'b1;
        nx        = cur_x + 8'd2;
      end
      default: if (cur_x >= 8'd2) begin
        in_bounds = 1'b1;
        nx        = cur_x - 8'd2;
      end
    endcase
    mid_x = 8'(({1'b0, cur_x} + {1'b0, nb_x_reg}) >> 1);
    mid_y = 8'(({1'b0, cur_y} + {1'b0, nb_y_reg}) >> 1);
  end

  always_comb begin
    state_next    = state_reg;
    fill_next     = fill_reg;
    sp_next       = sp_reg;
    dir_base_next = dir_base_reg;
    dir_cnt_next  = dir_cnt_reg;
    nb_x_next     = nb_x_reg;
    nb_y_next     = nb_y_reg;
    wait_next     = wait_reg;
    phase_next    = phase_reg;
    addr_next     = maze_address;
    we_next       = 1'b0;
    wd_next       = maze_write_data;
    busy_next     = busy;
    done_next     = done;
    lfsr_load     = 1'b0;
    push          = 1'b0;
    push_data     = 16'h0000;
    case (state_reg)
      ST_IDLE: if (start) begin
        state_next = ST_FILL;
        busy_next  = 1'b1;
        done_next  = 1'b0;
        fill_next  = 11'd0;
        lfsr_load  = 1'b1;
      end
      ST_FILL: begin
        addr_next = fill_reg;
        we_next   = 1'b1;
        wd_next   = WALL;
        fill_next = fill_reg + 11'd1;
        if (fill_reg == LAST_ADDR) state_next = ST_SEED;
      end
      ST_SEED: begin
        addr_next    = 11'd0;
        we_next      = 1'b1;
        wd_next      = FLOOR;
        push         = 1'b1;
        sp_next      = SP_W'(1);
        dir_cnt_next = 3'd0;
        state_next   = ST_PICK;
      end
      ST_PICK: begin
        if (dir_cnt_reg[2]) begin
          state_next = ST_POP;
        end else begin
          dir_base_next = base;
          if (in_bounds) begin
            nb_x_next  = nx;
            nb_y_next  = ny;
            addr_next  = tile_addr(W11, nx, ny);
            wait_next  = 8'd0;
            state_next = ST_PROBE;
          end else begin
            dir_cnt_next = dir_cnt_reg + 3'd1;
          end
        end
      end
      ST_PROBE: begin
        if (wait_reg == RL8) begin
          if (maze_read_data == WALL) begin
            phase_next = 1'b0;
            state_next = ST_CARVE;
          end else begin
            dir_cnt_next = dir_cnt_reg + 3'd1;
            state_next   = ST_PICK;
          end
        end else begin
          wait_next = wait_reg + 8'd1;
        end
      end
      ST_CARVE: begin
        we_next = 1'b1;
        wd_next = FLOOR;
        if (!phase_reg) begin
          addr_next  = tile_addr(W11, mid_x, mid_y);
          phase_next = 1'b1;
        end else begin
          addr_next    = tile_addr(W11, nb_x_reg, nb_y_reg);
          push         = 1'b1;
          push_data    = {nb_x_reg, nb_y_reg};
          sp_next      = sp_reg + SP_W'(1);
          dir_cnt_next = 3'd0;
          state_next   = ST_PICK;
        end
      end
      ST_POP: begin
        sp_next      = sp_reg - SP_W'(1);
        dir_cnt_next = 3'd0;
        state_next   = (sp_reg == SP_W'(1)) ? ST_EXIT : ST_PICK;
      end
      ST_EXIT: begin
        // An even height leaves the bottom row outside the cell grid; open one exit tile.
        if (HEIGHT % 2 == 0) begin
          addr_next = tile_addr(W11, XL8, EXIT_Y);
          we_next   = 1'b1;
          wd_next   = FLOOR;
        end
        state_next = ST_DONE;
      end
      ST_DONE: begin
        busy_next  = 1'b0;
        done_next  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg         <= ST_IDLE;
      fill_reg          <= 11'd0;
      sp_reg            <= '0;
      dir_base_reg      <= 2'd0;
      dir_cnt_reg       <= 3'd0;
      nb_x_reg          <= 8'd0;
      nb_y_reg          <= 8'd0;
      wait_reg          <= 8'd0;
      phase_reg         <= 1'b0;
      maze_address      <= 11'd0;
      maze_write_enable <= 1'b0;
      maze_write_data   <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      if (state_reg == ST_POP) assert (sp_reg != '0);
      state_reg         <= state_next;
      fill_reg          <= fill_next;
      sp_reg            <= sp_next;
      dir_base_reg      <= dir_base_next;
      dir_cnt_reg       <= dir_cnt_next;
      nb_x_reg          <= nb_x_next;
      nb_y_reg          <= nb_y_next;
      wait_reg          <= wait_next;
      phase_reg         <= phase_next;
      maze_address      <= addr_next;
      maze_write_enable <= we_next;
      maze_write_data   <= wd_next;
      busy              <= busy_next;
      done              <= done_next;
    end
  end

  always_ff @(posedge clock) begin
    if (push) stack[sp_reg] <= push_data;
  end

endmodule

// File: doc/maze_generator.md
Name: maze_generator

Overview:
Fills the 1-bit maze tile RAM with a random perfect maze before play starts. It drives the RAM's write port, and reads back through the same address bus. The player-movement logic reads this RAM during play. Cells sit at even (x,y) coordinates, odd coordinates are walls between cells, and (0,0) is the start cell. Carving uses a randomised depth-first backtracker with an internal stack and a 16-bit LFSR.

Parameters:
WIDTH, 10, maze width in tiles; 3..64, WIDTH*HEIGHT <= 2048
HEIGHT, 10, maze height in tiles; 3..64
READ_LATENCY, 2, rising edges from a read address being driven to maze_read_data being valid

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  pulse; begins generation when idle
rand_seed  in  16  LFSR seed, captured on accepted start
maze_read_data  in  1  tile at maze_address (1=WALL, 0=FLOOR)
maze_address  out  11  tile address = WIDTH*y + x
maze_write_enable  out  1  write strobe for maze_write_data at maze_address
maze_write_data  out  1  tile value to write
busy  out  1  high from accepted start until done
done  out  1  high once the maze is complete; held until next accepted start or reset

Behaviour:
- Clock and reset: one clock, `clock`; `reset` is asynchronous and active-high.
- Reset values: maze_address=0, maze_write_enable=0, maze_write_data=0, busy=0, done=0, stack pointer=0, state=IDLE.
- Reset asserted mid-operation aborts immediately. RAM contents are then undefined and no further writes occur.
- All outputs are registered.
- LFSR: Galois, taps 16'hB400. Loaded with rand_seed on an accepted start; a seed of 0 is replaced by 16'hACE1. It advances every cycle while busy.
- Derived constants:
  - XL = largest even value <= WIDTH-1; YL = largest even value <= HEIGHT-1.
  - CELLS = (XL/2+1)*(YL/2+1).
  - Stack depth = CELLS; each entry holds {x[7:0], y[7:0]}.
- States:
  - IDLE: start=1 → FILL, busy=1, done=0. start is ignored in every other state.
  - FILL: writes WALL to addresses 0..WIDTH*HEIGHT-1, one per cycle (write_enable=1) → SEED.
  - SEED: writes FLOOR at (0,0), pushes (0,0) → PICK.
  - PICK: current = top of stack. Directions are tried in the order d0=lfsr[1:0], d0+1, d0+2, d0+3 (mod 4), with UP=0, DOWN=1, RIGHT=2, LEFT=3. Neighbour = current ±2 in that axis. Out-of-bounds neighbours (y-2<0, y+2>YL, x+2>XL, x-2<0) are skipped without a read. Each in-bounds neighbour → PROBE.
  - PROBE: drives the neighbour address with write_enable=0, waits READ_LATENCY edges, then samples maze_read_data.
    - WALL (unvisited) → CARVE.
    - FLOOR → next direction.
    - All four directions exhausted → POP.
  - CARVE: two write cycles, first the intermediate wall tile (current ±1) to FLOOR, then the neighbour to FLOOR. Pushes the neighbour → PICK.
  - POP: decrements the stack pointer. If it is now 0 → EXIT, else → PICK.
  - EXIT: if HEIGHT is even, writes FLOOR at (XL, HEIGHT-1) so the exit tile is reachable; otherwise no write. → DONE.
  - DONE: busy=0, done=1, write_enable=0 → IDLE, holding done.
- Stack invariants: each cell is pushed exactly once, so the stack cannot overflow. POP on an empty stack is unreachable; assert this in simulation.
- Result: a spanning tree over CELLS cells. Final FLOOR count = 2*CELLS-1, plus 1 if HEIGHT is even.
- Arithmetic: address is computed at 11 bits, WIDTH*y + x, with no truncation for legal parameters. Coordinate arithmetic is 8-bit and signed-safe; bounds are checked before subtracting.
- A write and a read never occur in the same cycle.

Decomposition:
- Shared package holds:
  - tile constants FLOOR=1'b0 and WALL=1'b1;
  - direction encodings;
  - the address-calculation function, shared with the player-movement logic.
- One sub-module, maze_lfsr16 (seed load, enable, 16-bit state out).
- The stack is an in-module register array.

Test Plan:
- WIDTH=HEIGHT=5, seed 16'h1234, RAM model with latency 2 → done asserts. Required: 17 FLOOR tiles, all 9 even cells FLOOR, every odd/odd tile WALL, flood-fill from (0,0) reaches all floors, no cycles.
- WIDTH=HEIGHT=10 → 50 FLOOR tiles, (8,9) FLOOR, (0,0) FLOOR, row 9 FLOOR only at x=8.
- Same seed run twice → identical write sequence. Seed 0 → identical to seed 16'hACE1.
- Reset asserted at FILL address 37 → all outputs return to reset values asynchronously, no write afterward. New start → full correct maze.
- start pulsed during PROBE → ignored, single done, write count unchanged. start pulsed while done=1 → done clears next cycle, busy=1.
- WIDTH=HEIGHT=3 → 4 cells, 7 FLOOR tiles, (1,1) WALL, done within WIDTH*HEIGHT + 100 cycles.
